// File: rtl/reg_scoreboard.sv
// Read-side hazard tracker for regFile: per-register pending-write counters
// that stall decode while a source operand or the destination counter is busy.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issueValid,
    input  logic [4:0]      issueSrc1,
    input  logic [4:0]      issueSrc2,
    input  logic            useSrc1,
    input  logic            useSrc2,
    input  logic            issueWrites,
    input  logic [4:0]      issueDst,
    input  logic            wbValid,
    input  logic [4:0]      wbAdr,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] pendingMask,
    output logic            wbUnderflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREG];

    logic [CNT_W-1:0] src1Cnt;
    logic [CNT_W-1:0] src2Cnt;
    logic [CNT_W-1:0] dstCnt;
    logic             src1Hazard;
    logic             src2Hazard;
    logic             fullHazard;
    logic             issueFire;
    logic             incEn;
    logic             decEn;

    // A source whose last outstanding writer retires this cycle is bypassed,
    // because regFile writes on negedge and ID reads the new value.
    always_comb begin
        src1Cnt    = cnt[issueSrc1];
        src2Cnt    = cnt[issueSrc2];
        dstCnt     = cnt[issueDst];
        src1Hazard = useSrc1 && (issueSrc1 != 5'd0) && (src1Cnt != '0) &&
                     !(wbValid && (wbAdr == issueSrc1) && (src1Cnt == CNT_ONE));
        src2Hazard = useSrc2 && (issueSrc2 != 5'd0) && (src2Cnt != '0) &&
                     !(wbValid && (wbAdr == issueSrc2) && (src2Cnt == CNT_ONE));
        fullHazard = issueWrites && (issueDst != 5'd0) && (dstCnt == CNT_MAX);
        stall      = issueValid && !flush && (src1Hazard || src2Hazard || fullHazard);
        issueFire  = issueValid && !stall && !flush;
        incEn      = issueFire && issueWrites && (issueDst != 5'd0);
        decEn      = wbValid && (wbAdr != 5'd0) && !flush;
    end

    always_comb begin
        pendingMask = '0;
        for (int r = 1; r < NREG; r++) begin
            pendingMask[r] = (cnt[r] != '0);
        end
    end

    // Simultaneous issue and retire on one register cancel; a retire against
    // an empty counter is recorded in the sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            wbUnderflow <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (incEn && (issueDst == 5'(r)) && !(decEn && (wbAdr == 5'(r)))) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (decEn && (wbAdr == 5'(r)) && !(incEn && (issueDst == 5'(r)))) begin
                    if (cnt[r] != '0) begin
                        cnt[r] <= cnt[r] - CNT_ONE;
                    end else begin
                        wbUnderflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed per-cycle vectors push their
// hand-computed expectations into a queue that a negedge monitor drains.
module tb_reg_scoreboard;

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] mask;
        logic        uf;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        issueValid;
    logic [4:0]  issueSrc1;
    logic [4:0]  issueSrc2;
    logic        useSrc1;
    logic        useSrc2;
    logic        issueWrites;
    logic [4:0]  issueDst;
    logic        wbValid;
    logic [4:0]  wbAdr;
    logic        flush;
    logic        stall;
    logic [31:0] pendingMask;
    logic        wbUnderflow;

    expect_t expQ[$];
    int      checks = 0;
    int      errors = 0;

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .issueValid(issueValid),
        .issueSrc1(issueSrc1),
        .issueSrc2(issueSrc2),
        .useSrc1(useSrc1),
        .useSrc2(useSrc2),
        .issueWrites(issueWrites),
        .issueDst(issueDst),
        .wbValid(wbValid),
        .wbAdr(wbAdr),
        .flush(flush),
        .stall(stall),
        .pendingMask(pendingMask),
        .wbUnderflow(wbUnderflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s/%s: got %0h, expected %0h", name, field, actual, expected);
        end
    endtask

    // One vector per cycle: drive just after posedge, queue what the monitor
    // should see at the following negedge.
    task automatic applyStimulus(input string name, input logic rs, input logic iv,
                                 input logic [4:0] s1, input logic u1,
                                 input logic [4:0] s2, input logic u2,
                                 input logic w, input logic [4:0] dst,
                                 input logic wv, input logic [4:0] wa, input logic fl,
                                 input logic es, input logic [31:0] em, input logic eu);
        expect_t e;
        @(posedge clk);
        #1;
        rst = rs; issueValid = iv; issueSrc1 = s1; useSrc1 = u1;
        issueSrc2 = s2; useSrc2 = u2; issueWrites = w; issueDst = dst;
        wbValid = wv; wbAdr = wa; flush = fl;
        e.name = name; e.stall = es; e.mask = em; e.uf = eu;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expect_t e;
            e = expQ.pop_front();
            checkOutput(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
            checkOutput(e.name, "pendingMask", pendingMask, e.mask);
            checkOutput(e.name, "wbUnderflow", {31'd0, wbUnderflow}, {31'd0, e.uf});
        end
    end

    initial begin
        rst = 1'b1; issueValid = 0; issueSrc1 = 0; issueSrc2 = 0; useSrc1 = 0;
        useSrc2 = 0; issueWrites = 0; issueDst = 0; wbValid = 0; wbAdr = 0; flush = 0;
        @(posedge clk);

        //             name        rst iv s1 u1 s2 u2 w dst wv wa fl  stall mask      uf
        applyStimulus("reset",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,    0);
        applyStimulus("iss3",      0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0,  0, 32'h0,    0);
        applyStimulus("raw3a",     0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h8,    0);
        applyStimulus("raw3b",     0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h8,    0);
        applyStimulus("byp3",      0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0,  0, 32'h8,    0);
        applyStimulus("clr3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,    0);
        applyStimulus("iss5a",     0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 32'h0,    0);
        applyStimulus("iss5b",     0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 32'h20,   0);
        applyStimulus("iss5c",     0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 32'h20,   0);
        applyStimulus("full5",     0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  1, 32'h20,   0);
        applyStimulus("full5wb",   0, 1, 0, 0, 0, 0, 1, 5, 1, 5, 0,  1, 32'h20,   0);
        applyStimulus("iss5d",     0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 32'h20,   0);
        applyStimulus("wb5a",      0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 32'h20,   0);
        applyStimulus("src2noByp", 0, 1, 0, 0, 5, 1, 0, 0, 1, 5, 0,  1, 32'h20,   0);
        applyStimulus("useGate",   0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0,  0, 32'h20,   0);
        applyStimulus("wb5c",      0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 32'h20,   0);
        applyStimulus("clr5",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,    0);
        applyStimulus("iss7",      0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 32'h0,    0);
        applyStimulus("issWb7",    0, 1, 0, 0, 0, 0, 1, 7, 1, 7, 0,  0, 32'h80,   0);
        applyStimulus("hold7",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,   0);
        applyStimulus("wb7",       0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 32'h80,   0);
        applyStimulus("zeroIss",   0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0,  0, 32'h0,    0);
        applyStimulus("zeroWb",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 32'h0,    0);
        applyStimulus("wb9under",  0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 32'h0,    0);
        applyStimulus("ufSticky",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,    1);
        applyStimulus("iss2",      0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0,  0, 32'h0,    1);
        applyStimulus("iss4",      0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0,  0, 32'h4,    1);
        applyStimulus("iss6",      0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0,  0, 32'h14,   1);
        applyStimulus("flush",     0, 1, 2, 1, 0, 0, 1, 8, 1, 6, 1,  0, 32'h54,   1);
        applyStimulus("postFlush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,    1);
        applyStimulus("iss10",     0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 32'h0,    1);
        applyStimulus("rstPrio",   1, 1, 0, 0, 0, 0, 1, 11, 1, 10, 0, 0, 32'h400, 1);
        applyStimulus("postRst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,    0);

        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(negedge clk);
        end
        #2;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
